// File: rtl/pwm_deadtime.sv
// Complementary PWM output stage with programmable dead time and latched fault.
// Gate drives are decoded from the state register only, so high and low sides can never overlap.
module pwm_deadtime #(
    parameter int unsigned DT_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                pwm_i,
    input  logic [DT_WIDTH-1:0] cfg_dead,
    input  logic                fault_i,
    input  logic                fault_clr_i,
    output logic                pwm_hi_o,
    output logic                pwm_lo_o,
    output logic                dead_o,
    output logic                fault_o
);

    typedef enum logic [2:0] {
        S_OFF,
        S_DT_H,
        S_HI,
        S_DT_L,
        S_LO,
        S_FAULT
    } state_e;

    state_e              state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q,   cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (fault_i) begin
            state_d = S_FAULT;
            cnt_d   = '0;
        end else if (state_q == S_FAULT) begin
            // Clear is only honoured once the fault source itself has gone away.
            if (fault_clr_i) begin
                state_d = S_OFF;
            end
        end else if (!en_i) begin
            state_d = S_OFF;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_OFF: begin
                    state_d = pwm_i ? S_DT_H : S_DT_L;
                    cnt_d   = cfg_dead;
                end
                S_DT_H: begin
                    if (!pwm_i) begin
                        state_d = S_DT_L;
                        cnt_d   = cfg_dead;
                    end else if (cnt_q == '0) begin
                        state_d = S_HI;
                    end else begin
                        cnt_d = cnt_q - DT_WIDTH'(1);
                    end
                end
                S_DT_L: begin
                    if (pwm_i) begin
                        state_d = S_DT_H;
                        cnt_d   = cfg_dead;
                    end else if (cnt_q == '0) begin
                        state_d = S_LO;
                    end else begin
                        cnt_d = cnt_q - DT_WIDTH'(1);
                    end
                end
                S_HI: begin
                    if (!pwm_i) begin
                        state_d = S_DT_L;
                        cnt_d   = cfg_dead;
                    end
                end
                S_LO: begin
                    if (pwm_i) begin
                        state_d = S_DT_H;
                        cnt_d   = cfg_dead;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pwm_hi_o = (state_q == S_HI);
        pwm_lo_o = (state_q == S_LO);
        dead_o   = (state_q == S_DT_H) || (state_q == S_DT_L);
        fault_o  = (state_q == S_FAULT);
    end

endmodule
